// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports (SPI, host) plus the data-memory port.
// The arbiter uses the slave modport; requesters/memory model use the master modport.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic              spi_req;
    logic              spi_we;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_ack;
    logic [DATA_W-1:0] spi_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata,
        output spi_ack, spi_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata,
        input  spi_ack, spi_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: SPI has fixed priority, host gets a grant after
// MAX_SPI_STREAK consecutive SPI grants while it waits. Each access takes IDLE/ACCESS/RESP.
module dm_arbiter #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned MAX_SPI_STREAK = 4
) (
    input logic         clk,
    input logic         rst_n,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] StreakMax = 4'(MAX_SPI_STREAK);

    state_e            state_q, state_d;
    logic [3:0]        streak_q;
    logic              win_host_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              spi_ack_q, host_ack_q;
    logic [DATA_W-1:0] spi_rdata_q, host_rdata_q;
    logic              grant, grant_host, busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.spi_req || bus.host_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        grant      = (state_q == StIdle) && (bus.spi_req || bus.host_req);
        // Host wins when alone, or when SPI has used up its streak allowance.
        grant_host = bus.host_req && (!bus.spi_req || streak_q == StreakMax);
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q     <= '0;
            win_host_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            spi_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            spi_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            mem_we_q   <= 1'b0;
            spi_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            if (grant) begin
                win_host_q  <= grant_host;
                mem_addr_q  <= grant_host ? bus.host_addr  : bus.spi_addr;
                mem_wdata_q <= grant_host ? bus.host_wdata : bus.spi_wdata;
                mem_we_q    <= grant_host ? bus.host_we    : bus.spi_we;
                if (!grant_host && bus.host_req) begin
                    streak_q <= (streak_q >= StreakMax) ? StreakMax : 4'(streak_q + 4'd1);
                end else begin
                    streak_q <= '0;
                end
            end
            if (state_q == StAccess) begin
                if (win_host_q) begin
                    host_ack_q <= 1'b1;
                    if (!mem_we_q) host_rdata_q <= bus.mem_rdata;
                end else begin
                    spi_ack_q <= 1'b1;
                    if (!mem_we_q) spi_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.spi_ack    = spi_ack_q;
    assign bus.spi_rdata  = spi_rdata_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small synchronous-write/combinational-read memory model.
module tb_dm_arbiter;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_SPI_STREAK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [128];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] <= (i == 0) ? 8'h5A : (i == 127) ? 8'hC3 : 8'h00;
            end
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int checks = 0;
    int failures = 0;
    int spi_acks = 0;
    int host_acks = 0;
    int we_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, keep event counts and invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.spi_ack) spi_acks++;
        if (bus.host_ack) host_acks++;
        if (bus.mem_we) we_cycles++;
        check_eq("both_ack", 32'(bus.spi_ack & bus.host_ack), 32'h0);
        check_eq("we_outside_access", 32'(bus.mem_we & ~bus.busy), 32'h0);
    endtask

    task automatic wait_ack(input bit host, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            seen = host ? bus.host_ack : bus.spi_ack;
        end
        if (!seen) check_eq(host ? "host_ack_timeout" : "spi_ack_timeout", 32'h0, 32'h1);
    endtask

    int cyc, n0, h0, w0;

    initial begin
        bus.spi_req = 0; bus.spi_we = 0; bus.spi_addr = '0; bus.spi_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_spi_ack", 32'(bus.spi_ack), 32'h0);
        check_eq("rst_host_ack", 32'(bus.host_ack), 32'h0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check_eq("rst_spi_rdata", 32'(bus.spi_rdata), 32'h0);
        preload = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // SPI write then read back
        w0 = we_cycles;
        bus.spi_we = 1; bus.spi_addr = 7'h05; bus.spi_wdata = 8'hA5; bus.spi_req = 1;
        wait_ack(1'b0, cyc);
        check_eq("wr_latency", 32'(cyc), 32'd2);
        bus.spi_req = 0;
        step();
        check_eq("wr_we_cycles", 32'(we_cycles - w0), 32'd1);
        check_eq("wr_mem", 32'(mem[5]), 32'hA5);
        bus.spi_we = 0; bus.spi_req = 1;
        wait_ack(1'b0, cyc);
        check_eq("rd_latency", 32'(cyc), 32'd2);
        check_eq("rd_spi_rdata", 32'(bus.spi_rdata), 32'hA5);
        bus.spi_req = 0;
        step();
        check_eq("rd_no_host_ack", 32'(host_acks), 32'd0);

        // Contention: SPI write first, host read sees the new value
        bus.spi_we = 1; bus.spi_addr = 7'h10; bus.spi_wdata = 8'h11;
        bus.host_we = 0; bus.host_addr = 7'h10;
        bus.spi_req = 1; bus.host_req = 1;
        wait_ack(1'b0, cyc);
        check_eq("cont_spi_first", 32'(cyc), 32'd2);
        check_eq("cont_host_waits", 32'(host_acks), 32'd0);
        bus.spi_req = 0;
        wait_ack(1'b1, cyc);
        check_eq("cont_host_latency", 32'(cyc), 32'd3);
        check_eq("cont_host_rdata", 32'(bus.host_rdata), 32'h11);
        bus.host_req = 0;
        step();

        // Starvation bound: 4 SPI grants then one host grant
        bus.spi_we = 1; bus.spi_addr = 7'h20; bus.spi_wdata = 8'h77;
        bus.host_we = 0; bus.host_addr = 7'h20;
        bus.spi_req = 1; bus.host_req = 1;
        n0 = spi_acks; h0 = host_acks;
        for (int i = 0; i < 40 && host_acks == h0; i++) step();
        check_eq("starve_spi_count", 32'(spi_acks - n0), 32'd4);
        check_eq("starve_host_ack", 32'(host_acks - h0), 32'd1);
        check_eq("starve_host_rdata", 32'(bus.host_rdata), 32'h77);
        // host keeps requesting: a cleared streak must give SPI the next grant
        h0 = host_acks;
        wait_ack(1'b0, cyc);
        check_eq("starve_spi_resume", 32'(cyc), 32'd3);
        check_eq("starve_no_host", 32'(host_acks - h0), 32'd0);
        bus.spi_req = 0;
        wait_ack(1'b1, cyc);
        check_eq("starve_host_again", 32'(cyc), 32'd3);
        bus.host_req = 0;
        step();
        check_eq("wr_keeps_rdata", 32'(bus.spi_rdata), 32'hA5);

        // Withdrawal: SPI pulses req only during a host access
        w0 = we_cycles; n0 = spi_acks;
        bus.host_we = 1; bus.host_addr = 7'h30; bus.host_wdata = 8'h3C; bus.host_req = 1;
        step();
        check_eq("wd_host_we", 32'(bus.mem_we), 32'h1);
        bus.spi_we = 1; bus.spi_addr = 7'h31; bus.spi_wdata = 8'hEE; bus.spi_req = 1;
        step();
        check_eq("wd_host_ack", 32'(bus.host_ack), 32'h1);
        bus.spi_req = 0; bus.host_req = 0;
        repeat (4) step();
        check_eq("wd_we_cycles", 32'(we_cycles - w0), 32'd1);
        check_eq("wd_no_spi_ack", 32'(spi_acks - n0), 32'd0);
        check_eq("wd_mem31", 32'(mem[7'h31]), 32'h00);
        check_eq("wd_mem30", 32'(mem[7'h30]), 32'h3C);

        // Reset during ACCESS of a write to 0x7F
        bus.spi_we = 1; bus.spi_addr = 7'h7F; bus.spi_wdata = 8'h99; bus.spi_req = 1;
        step();
        check_eq("rm_we_before", 32'(bus.mem_we), 32'h1);
        check_eq("rm_addr_before", 32'(bus.mem_addr), 32'h7F);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rm_mem_we", 32'(bus.mem_we), 32'h0);
        check_eq("rm_mem_addr", 32'(bus.mem_addr), 32'h0);
        check_eq("rm_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check_eq("rm_busy", 32'(bus.busy), 32'h0);
        check_eq("rm_spi_rdata", 32'(bus.spi_rdata), 32'h0);
        check_eq("rm_host_rdata", 32'(bus.host_rdata), 32'h0);
        bus.spi_req = 0;
        n0 = spi_acks;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) step();
        check_eq("rm_no_ack", 32'(spi_acks - n0), 32'd0);
        check_eq("rm_mem7f", 32'(mem[7'h7F]), 32'hC3);

        // Back-to-back host reads 0x00 then 0x7F
        bus.host_we = 0; bus.host_addr = 7'h00; bus.host_req = 1;
        wait_ack(1'b1, cyc);
        check_eq("b2b_rdata0", 32'(bus.host_rdata), 32'h5A);
        bus.host_addr = 7'h7F;
        step();
        check_eq("b2b_idle_busy", 32'(bus.busy), 32'h0);
        step();
        check_eq("b2b_access_busy", 32'(bus.busy), 32'h1);
        wait_ack(1'b1, cyc);
        check_eq("b2b_gap", 32'(cyc), 32'd1);
        check_eq("b2b_resp_busy", 32'(bus.busy), 32'h1);
        check_eq("b2b_rdata7f", 32'(bus.host_rdata), 32'hC3);
        bus.host_req = 0;
        step();
        check_eq("b2b_end_busy", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
